// File: rtl/proc_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Holds the FIFO entry layout and the fetch-word geometry used by the parent and the FIFO.
package proc_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } ifq_entry_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int unsigned WORD_BYTES = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of ifq_entry_t with a flush input.
// Occupancy is tracked with a counter, so full and empty never depend on pointer equality.
module ifq_fifo
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  ifq_entry_t      wdata,
    output ifq_entry_t      rdata,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);

    ifq_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only slots covered by count are ever read out.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_queue.sv
// Decoupled instruction prefetch queue: issues imem requests, buffers tagged responses, flushes on redirect.
// Define IFQ_BYPASS_EN to present a response directly on the outputs when the FIFO is empty.
module instr_fetch_queue
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        pop,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        err,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   push_pc_q, push_pc_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    ifq_entry_t    fifo_wdata, fifo_rdata;
    logic [CW:0]   occupancy;
    logic          grant, rsp_keep, bypass;

    // Reserving FIFO space for every outstanding request is what makes overflow impossible.
    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign imem_req  = !rst && !redirect_valid && (occupancy < (CW + 1)'(DEPTH))
                       && (outstanding_q < CW'(MAX_OUTSTANDING));
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;
    assign rsp_keep  = imem_rvalid && (discard_q == '0) && !redirect_valid;

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp_keep && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_wdata = '{pc: push_pc_q, instr: imem_rdata, err: imem_err};
    assign fifo_push  = rsp_keep && !(bypass && pop);
    assign fifo_pop   = pop && !fifo_empty && !redirect_valid && !bypass;

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (redirect_valid),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        instr_valid = 1'b0;
        instr       = NOP_INSTR;
        pc          = push_pc_q;
        err         = 1'b0;
        if (bypass) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            err         = imem_err;
        end else if (!fifo_empty) begin
            instr_valid = 1'b1;
            instr       = fifo_rdata.instr;
            pc          = fifo_rdata.pc;
            err         = fifo_rdata.err;
        end
    end

    // A redirect turns every request still in flight into one to drop, except a response landing now.
    always_comb begin
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
        discard_d     = discard_q;
        fetch_pc_d    = fetch_pc_q;
        push_pc_d     = push_pc_q;
        if (redirect_valid) begin
            discard_d  = outstanding_q - CW'(imem_rvalid);
            fetch_pc_d = word_align(redirect_addr);
            push_pc_d  = word_align(redirect_addr);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
            if (imem_rvalid) begin
                if (discard_q != '0) discard_d = discard_q - CW'(1);
                else                 push_pc_d = push_pc_q + 32'(WORD_BYTES);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            discard_q     <= '0;
            fetch_pc_q    <= RESET_PC;
            push_pc_q     <= RESET_PC;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fetch_pc_q    <= fetch_pc_d;
            push_pc_q     <= push_pc_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue with an in-order memory model and an entry scoreboard.
// Build with +define+IFQ_BYPASS_EN to check the bypass latency instead of the registered one.
module tb_instr_fetch_queue;
    import proc_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        stale;
    } inflight_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        pop;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;

    ifq_entry_t  expQ[$];
    inflight_t   inflight[$];
    logic [31:0] expFetchPc;
    logic [31:0] errAddr;
    int          testCount = 0;
    int          failCount = 0;
    int          cycNum = 0;
    int          firstRvalidCyc = -1;
    int          firstValidCyc = -1;

    instr_fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .pop            (pop),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .err            (err),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle, entered and left on a falling edge; memory answers one cycle after a grant.
    task automatic applyStimulus(input logic doPop, input logic doRedir, input logic [31:0] rAddr,
                                 input logic doGnt, input logic doResp);
        logic       respNow, respGood, expReq, expValid;
        int         cntBefore, outBefore;
        ifq_entry_t rsp;
        pop            = doPop;
        redirect_valid = doRedir;
        redirect_addr  = rAddr;
        imem_gnt       = doGnt;
        respNow        = doResp && (inflight.size() > 0);
        imem_rvalid    = respNow;
        imem_rdata     = 32'h0;
        imem_err       = 1'b0;
        rsp            = '{pc: 32'h0, instr: 32'h0, err: 1'b0};
        if (respNow) begin
            imem_rdata = inflight[0].addr + 32'h100;
            imem_err   = (inflight[0].addr == errAddr);
            rsp        = '{pc: inflight[0].addr, instr: imem_rdata, err: imem_err};
        end
        #1;
        cntBefore = expQ.size();
        outBefore = inflight.size();
        expReq    = !doRedir && (cntBefore + outBefore < 4) && (outBefore < 2);
        checkOutput("imem_req", 32'(imem_req), 32'(expReq));
        if (expReq) checkOutput("imem_addr", imem_addr, expFetchPc);
        respGood = respNow && !inflight[0].stale && !doRedir;
`ifdef IFQ_BYPASS_EN
        if (respGood && cntBefore == 0) expQ.push_back(rsp);
`endif
        expValid = (expQ.size() > 0);
        checkOutput("instr_valid", 32'(instr_valid), 32'(expValid));
        if (expValid) begin
            checkOutput("head_instr", instr, expQ[0].instr);
            checkOutput("head_pc", pc, expQ[0].pc);
            checkOutput("head_err", 32'(err), 32'(expQ[0].err));
        end else begin
            checkOutput("empty_instr", instr, NOP_INSTR);
        end
        if (respNow && firstRvalidCyc < 0) firstRvalidCyc = cycNum;
        if (instr_valid && firstValidCyc < 0) firstValidCyc = cycNum;
        if (doPop && expValid && !doRedir) void'(expQ.pop_front());
`ifdef IFQ_BYPASS_EN
        if (respGood && cntBefore != 0) expQ.push_back(rsp);
`else
        if (respGood) expQ.push_back(rsp);
`endif
        if (respNow) void'(inflight.pop_front());
        if (expReq && doGnt) begin
            inflight.push_back('{addr: expFetchPc, stale: 1'b0});
            expFetchPc = expFetchPc + 32'd4;
        end
        if (doRedir) begin
            expQ.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            expFetchPc = rAddr & ~32'h3;
        end
        cycNum++;
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        pop            = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        imem_err       = 1'b0;
        expFetchPc     = 32'h0;
        errAddr        = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("rst_instr", instr, NOP_INSTR);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Fill with pop held low: requests must stop once FIFO plus in-flight reaches depth.
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("fill_count", 32'(expQ.size()), 32'd4);
`ifdef IFQ_BYPASS_EN
        checkOutput("first_latency", 32'(firstValidCyc - firstRvalidCyc), 32'd0);
`else
        checkOutput("first_latency", 32'(firstValidCyc - firstRvalidCyc), 32'd1);
`endif

        // Drain in PC order while requests resume.
        repeat (10) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Build two outstanding requests, then redirect; both late responses must vanish.
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("outstanding_before_redirect", 32'(inflight.size()), 32'd2);
        applyStimulus(1'b1, 1'b1, 32'h0000_2003, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("redirect_first_pc", pc, 32'h0000_2000);
        repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect coinciding with a response and a pop, with two requests in flight.
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
        #1;
        checkOutput("flush_empty", 32'(instr_valid), 32'h0);
        #4;
        @(negedge clk);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Access fault on address 0x8 is delivered with err set, fetching continues.
        errAddr = 32'h8;
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
        repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #100000;
        failCount++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
